// File: rtl/lza_norm_shift_pkg.sv
// fpu_norm_pkg: shared widths and stage-1 payload for the LZA normalization stage
package fpu_norm_pkg;
    localparam int MANT_W = 27;
    localparam int EXP_W  = 8;
    localparam int LZ_W   = $clog2(MANT_W) + 1;

    typedef struct packed {
        logic [MANT_W-1:0] sum;
        logic [EXP_W-1:0]  exp;
        logic              sign;
        logic [LZ_W-1:0]   lz;
        logic              zero;
    } s1_t;
endpackage

// File: rtl/lza_norm_shift_lead_one_enc.sv
// lead_one_enc: priority encoder giving the leading-zero count of the LZA indicator vector
module lead_one_enc
    import fpu_norm_pkg::*;
(
    input  logic [MANT_W-1:0] vec_i,
    output logic [LZ_W-1:0]   lz_o,
    output logic              zero_o
);
    // Scan from LSB upward so the highest set bit wins; an empty vector reports MANT_W.
    always_comb begin
        lz_o = LZ_W'(MANT_W);
        for (int i = 0; i < MANT_W; i++)
            if (vec_i[i]) lz_o = LZ_W'(MANT_W - 1 - i);
        zero_o = (vec_i == '0);
    end
endmodule

// File: rtl/lza_norm_shift.sv
// lza_norm_shift: 2-stage LZA normalize/correct/exponent-adjust pipeline; LZA_NORM_CORR_CNT_EN adds corr_count
module lza_norm_shift
    import fpu_norm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MANT_W-1:0] in_sum,
    input  logic [MANT_W-1:0] in_ind,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic              in_sign,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W-1:0] out_mant,
    output logic [EXP_W-1:0]  out_exp,
    output logic              out_sign,
    output logic              out_zero,
    output logic              out_underflow
`ifdef LZA_NORM_CORR_CNT_EN
    ,
    output logic [15:0]       corr_count
`endif
);
    s1_t               s1_d, s1_q;
    logic              s1_v_q, s2_v_q, s2_load;
    logic [LZ_W-1:0]   enc_lz, lz_tot;
    logic              enc_zero, corr, uf;
    logic [MANT_W-1:0] t, mant_d, mant_q;
    logic [EXP_W:0]    lz_x, exp_x, eff;
    logic [EXP_W-1:0]  exp_d, exp_q;
    logic              sign_q, zero_q, uf_d, uf_q;

    lead_one_enc u_enc (.vec_i(in_ind), .lz_o(enc_lz), .zero_o(enc_zero));

    assign s2_load  = !s2_v_q || out_ready;
    assign in_ready = !s1_v_q || s2_load;
    assign s1_d     = '{sum: in_sum, exp: in_exp, sign: in_sign, lz: enc_lz,
                        zero: enc_zero || (in_sum == '0)};

    // Stage 1: capture payload plus anticipated shift whenever the stage is free or draining.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q <= 1'b0;
            s1_q   <= '0;
        end else if (in_ready) begin
            s1_v_q <= in_valid;
            if (in_valid) s1_q <= s1_d;
        end
    end

    // Stage 2 math: 1-bit LZA correction, then clamp the shift to the exponent (9-bit, no wrap).
    always_comb begin
        t      = s1_q.sum << s1_q.lz;
        corr   = !t[MANT_W-1] && !s1_q.zero;
        lz_tot = s1_q.lz + LZ_W'(corr);
        lz_x   = (EXP_W+1)'(lz_tot);
        exp_x  = {1'b0, s1_q.exp};
        uf     = lz_x > exp_x;
        eff    = uf ? exp_x : lz_x;
        mant_d = s1_q.zero ? '0 : s1_q.sum << eff;
        exp_d  = s1_q.zero ? '0 : EXP_W'(exp_x - eff);
        uf_d   = uf && !s1_q.zero;
    end

    // Stage 2: output register, held while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_v_q <= 1'b0;
            mant_q <= '0;
            exp_q  <= '0;
            sign_q <= 1'b0;
            zero_q <= 1'b0;
            uf_q   <= 1'b0;
        end else if (s2_load) begin
            s2_v_q <= s1_v_q;
            if (s1_v_q) begin
                mant_q <= mant_d;
                exp_q  <= exp_d;
                sign_q <= s1_q.sign;
                zero_q <= s1_q.zero;
                uf_q   <= uf_d;
            end
        end
    end

    assign out_valid     = s2_v_q;
    assign out_mant      = mant_q;
    assign out_exp       = exp_q;
    assign out_sign      = sign_q;
    assign out_zero      = zero_q;
    assign out_underflow = uf_q;

`ifdef LZA_NORM_CORR_CNT_EN
    logic        corr_q;
    logic [15:0] cnt_q;

    // Correction flag travels with the S2 beat; count it only when that beat is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            corr_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            if (s2_load && s1_v_q) corr_q <= corr;
            if (s2_v_q && out_ready && corr_q && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
        end
    end

    assign corr_count = cnt_q;
`endif
endmodule

// File: tb/tb_lza_norm_shift.sv
// tb_lza_norm_shift: randomized scoreboard bench for lza_norm_shift; checks corr_count when LZA_NORM_CORR_CNT_EN is set
module tb_lza_norm_shift;
    typedef struct {
        logic [26:0] mant;
        logic [7:0]  exp;
        logic        sign;
        logic        zero;
        logic        uf;
        logic        corr;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, in_sign, out_valid, out_ready;
    logic        out_sign, out_zero, out_underflow;
    logic [26:0] in_sum, in_ind, out_mant;
    logic [7:0]  in_exp, out_exp;
`ifdef LZA_NORM_CORR_CNT_EN
    logic [15:0] corr_count;
`endif

    int    n_tests = 0, n_fail = 0, mcnt = 0;
    logic  acc_in, acc_out;
    beat_t obs, e;
    beat_t expq[$];
    logic  cq[$];

    lza_norm_shift dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_sum(in_sum), .in_ind(in_ind), .in_exp(in_exp), .in_sign(in_sign),
        .out_valid(out_valid), .out_ready(out_ready), .out_mant(out_mant),
        .out_exp(out_exp), .out_sign(out_sign), .out_zero(out_zero),
        .out_underflow(out_underflow)
`ifdef LZA_NORM_CORR_CNT_EN
        , .corr_count(corr_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1);
    end

    // Reference: integer arithmetic straight from the normalization rules.
    function automatic beat_t model(logic [26:0] s, logic [26:0] ind, logic [7:0] ex, logic sg);
        beat_t r;
        int p = -1, lz, lzt, eff;
        longint sh;
        for (int i = 0; i < 27; i++) if (ind[i]) p = i;
        r.sign = sg;
        if (p < 0 || s == 0) begin
            r.mant = 0; r.exp = 0; r.zero = 1; r.uf = 0; r.corr = 0;
            return r;
        end
        lz   = 26 - p;
        sh   = (longint'(s) << lz) & 64'h7FF_FFFF;
        r.corr = ((sh >> 26) & 1) == 0;
        lzt  = lz + (r.corr ? 1 : 0);
        eff  = (lzt < int'(ex)) ? lzt : int'(ex);
        r.mant = 27'((longint'(s) << eff) & 64'h7FF_FFFF);
        r.exp  = 8'(int'(ex) - eff);
        r.uf   = lzt > int'(ex);
        r.zero = 0;
        return r;
    endfunction

    task automatic tick();
        @(negedge clk);
        acc_in  = in_valid && in_ready && !rst;
        acc_out = out_valid && out_ready && !rst;
        obs = '{mant: out_mant, exp: out_exp, sign: out_sign, zero: out_zero, uf: out_underflow, corr: 1'b0};
        if (rst) begin
            expq.delete(); cq.delete(); mcnt = 0;
        end
        if (acc_in) begin
            expq.push_back(model(in_sum, in_ind, in_exp, in_sign));
            cq.push_back(expq[$].corr);
        end
        if (acc_out && cq.size() > 0 && cq.pop_front() && mcnt < 65535) mcnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic gen(output logic [26:0] s, output logic [26:0] ind, output logic [7:0] ex, output logic sg);
        int mode = $urandom_range(0, 5);
        int p = -1;
        s = 27'($urandom) >> $urandom_range(0, 26);
        for (int i = 0; i < 27; i++) if (s[i]) p = i;
        ind = 27'($urandom);
        if (mode <= 1 && p >= 0) ind = 27'(1) << p;
        if (mode == 2 && p >= 0 && p < 26) ind = 27'(1) << (p + 1);
        if (mode == 3) s = 0;
        if (mode == 4) ind = 0;
        ex = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 30)) : 8'($urandom);
        sg = 1'($urandom);
    endtask

    task automatic test_reset();
        rst = 1; in_valid = 0; out_ready = 0; in_sum = 0; in_ind = 0; in_exp = 0; in_sign = 0;
        tick(); tick();
        rst = 0;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_flags: out_valid=%b in_ready=%b, want 0/1", out_valid, in_ready);
        end
        n_tests++;
        if ({out_mant, out_exp, out_sign, out_zero, out_underflow} !== '0) begin
            n_fail++; $display("FAIL reset_payload: mant=%h exp=%0d sign=%b zero=%b uf=%b, want all 0",
                               out_mant, out_exp, out_sign, out_zero, out_underflow);
        end
    endtask

    task automatic test_directed(string name, logic [26:0] s, logic [26:0] ind, logic [7:0] ex, logic sg,
                                 logic [26:0] xm, logic [7:0] xe, logic xz, logic xu, int xc);
        int c0 = mcnt;
        out_ready = 1;
        in_valid = 1; in_sum = s; in_ind = ind; in_exp = ex; in_sign = sg;
        tick();
        in_valid = 0;
        n_tests++;
        if (acc_in !== 1'b1) begin n_fail++; $display("FAIL %s_accept: accepted=%b want 1", name, acc_in); end
        tick();
        n_tests++;
        if (acc_out !== 1'b0) begin n_fail++; $display("FAIL %s_early: out_valid=1 after 1 cycle, want 0", name); end
        tick();
        n_tests++;
        if (acc_out !== 1'b1) begin
            n_fail++; $display("FAIL %s_latency: out_valid=%b at 2 cycles, want 1", name, acc_out);
        end else begin
            void'(expq.pop_front());
            if (obs.mant !== xm || obs.exp !== xe || obs.sign !== sg || obs.zero !== xz || obs.uf !== xu) begin
                n_fail++;
                $display("FAIL %s_data: got mant=%h exp=%0d sign=%b zero=%b uf=%b want mant=%h exp=%0d sign=%b zero=%b uf=%b",
                         name, obs.mant, obs.exp, obs.sign, obs.zero, obs.uf, xm, xe, sg, xz, xu);
            end
        end
`ifdef LZA_NORM_CORR_CNT_EN
        n_tests++;
        if (int'(corr_count) !== c0 + xc) begin
            n_fail++; $display("FAIL %s_corr_count: got %0d want %0d", name, corr_count, c0 + xc);
        end
`else
        if (c0 + xc < 0) $display("%s: negative count", name);
`endif
    endtask

    task automatic test_random();
        int got = 0;
        for (int k = 0; k < 600; k++) begin
            if (!in_valid || acc_in) begin
                in_valid = ($urandom_range(0, 3) != 0);
                gen(in_sum, in_ind, in_exp, in_sign);
            end
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
            if (acc_out) begin
                n_tests++;
                if (expq.size() == 0) begin
                    n_fail++; $display("FAIL rnd_extra: unexpected beat mant=%h", obs.mant);
                end else begin
                    e = expq.pop_front();
                    if ({obs.mant, obs.exp, obs.sign, obs.zero, obs.uf} !== {e.mant, e.exp, e.sign, e.zero, e.uf}) begin
                        n_fail++;
                        $display("FAIL rnd_beat%0d: got mant=%h exp=%0d s=%b z=%b uf=%b want mant=%h exp=%0d s=%b z=%b uf=%b",
                                 got, obs.mant, obs.exp, obs.sign, obs.zero, obs.uf, e.mant, e.exp, e.sign, e.zero, e.uf);
                    end
                end
                got++;
            end
        end
        in_valid = 0; out_ready = 1;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (acc_out) begin
                n_tests++;
                if (expq.size() == 0) begin
                    n_fail++; $display("FAIL drain_extra: unexpected beat mant=%h", obs.mant);
                end else begin
                    e = expq.pop_front();
                    if ({obs.mant, obs.exp, obs.sign, obs.zero, obs.uf} !== {e.mant, e.exp, e.sign, e.zero, e.uf}) begin
                        n_fail++;
                        $display("FAIL drain_beat: got mant=%h exp=%0d want mant=%h exp=%0d", obs.mant, obs.exp, e.mant, e.exp);
                    end
                end
            end
        end
        n_tests++;
        if (expq.size() != 0) begin n_fail++; $display("FAIL rnd_lost: %0d beats never emerged, want 0", expq.size()); end
`ifdef LZA_NORM_CORR_CNT_EN
        n_tests++;
        if (int'(corr_count) !== mcnt) begin n_fail++; $display("FAIL rnd_corr_count: got %0d want %0d", corr_count, mcnt); end
`endif
    endtask

    task automatic test_back_to_back();
        logic [26:0] bs[3], bi[3];
        logic [7:0]  be[3];
        logic        bg[3];
        int idx = 0, got = 0;
        for (int i = 0; i < 3; i++) gen(bs[i], bi[i], be[i], bg[i]);
        out_ready = 0;
        for (int k = 0; k < 4; k++) begin
            in_valid = idx < 3;
            in_sum = bs[idx < 3 ? idx : 0]; in_ind = bi[idx < 3 ? idx : 0];
            in_exp = be[idx < 3 ? idx : 0]; in_sign = bg[idx < 3 ? idx : 0];
            tick();
            if (acc_in) idx++;
        end
        n_tests++;
        if (idx !== 2 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_stall: accepted=%0d in_ready=%b, want 2/0", idx, in_ready);
        end
        out_ready = 1;
        for (int k = 0; k < 20; k++) begin
            in_valid = idx < 3;
            in_sum = bs[idx < 3 ? idx : 0]; in_ind = bi[idx < 3 ? idx : 0];
            in_exp = be[idx < 3 ? idx : 0]; in_sign = bg[idx < 3 ? idx : 0];
            tick();
            if (acc_in) idx++;
            if (acc_out) begin
                n_tests++;
                if (expq.size() == 0) begin
                    n_fail++; $display("FAIL bp_dup: extra beat mant=%h", obs.mant);
                end else begin
                    e = expq.pop_front();
                    if ({obs.mant, obs.exp, obs.sign, obs.zero, obs.uf} !== {e.mant, e.exp, e.sign, e.zero, e.uf}) begin
                        n_fail++;
                        $display("FAIL bp_beat%0d: got mant=%h exp=%0d want mant=%h exp=%0d", got, obs.mant, obs.exp, e.mant, e.exp);
                    end
                end
                got++;
            end
        end
        in_valid = 0;
        n_tests++;
        if (got !== 3 || idx !== 3) begin n_fail++; $display("FAIL bp_count: emitted=%0d accepted=%0d, want 3/3", got, idx); end
    endtask

    task automatic test_reset_mid();
        int extra = 0;
        out_ready = 0;
        in_valid = 1; in_sum = 27'h0400000; in_ind = 27'h0400000; in_exp = 8'd100; in_sign = 1;
        tick(); tick();
        in_valid = 0; rst = 1;
        tick();
        rst = 0;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
            {out_mant, out_exp, out_sign, out_zero, out_underflow} !== '0) begin
            n_fail++; $display("FAIL rmid_clear: out_valid=%b in_ready=%b mant=%h exp=%0d sign=%b, want 0/1/0/0/0",
                               out_valid, in_ready, out_mant, out_exp, out_sign);
        end
        out_ready = 1;
        in_valid = 1; in_sum = 27'h0000300; in_ind = 27'h0000200; in_exp = 8'd50; in_sign = 0;
        tick();
        in_valid = 0;
        tick();
        n_tests++;
        if (acc_out !== 1'b0) begin n_fail++; $display("FAIL rmid_early: got out_valid=1 after 1 cycle, want 0"); end
        tick();
        n_tests++;
        if (acc_out !== 1'b1 || obs.mant !== 27'h6000000 || obs.exp !== 8'd33 || obs.uf !== 1'b0) begin
            n_fail++; $display("FAIL rmid_beat: got valid=%b mant=%h exp=%0d uf=%b want 1 6000000 33 0",
                               acc_out, obs.mant, obs.exp, obs.uf);
        end
        if (acc_out) void'(expq.pop_front());
        for (int k = 0; k < 4; k++) begin
            tick();
            if (acc_out) extra++;
        end
        n_tests++;
        if (extra !== 0) begin n_fail++; $display("FAIL rmid_ghost: got %0d stale beats, want 0", extra); end
    endtask

    initial begin
        test_reset();
        test_directed("exact", 27'h0400000, 27'h0400000, 8'd100, 1'b0, 27'h4000000, 8'd96, 1'b0, 1'b0, 0);
        test_directed("corr",  27'h0400000, 27'h0800000, 8'd100, 1'b0, 27'h4000000, 8'd96, 1'b0, 1'b0, 1);
        test_directed("zero",  27'h0000000, 27'h0000000, 8'd77,  1'b1, 27'h0000000, 8'd0,  1'b1, 1'b0, 0);
        test_directed("uflow", 27'h0000008, 27'h0000008, 8'd10,  1'b0, 27'h0002000, 8'd0,  1'b0, 1'b1, 0);
        test_directed("sumz",  27'h0000000, 27'h0001000, 8'd20,  1'b0, 27'h0000000, 8'd0,  1'b1, 1'b0, 0);
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
